// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing helpers for the reorder buffer and its entry storage.
package reorder_buffer_pkg;
    localparam int XLEN        = 32;
    localparam int REG_IDX_LEN = 5;
    localparam int QUERY_PORTS = 2;

    typedef struct packed {
        logic                   valid;
        logic                   done;
        logic                   mispredict;
        logic [REG_IDX_LEN-1:0] rd;
        logic [XLEN-1:0]        data;
        logic [XLEN-1:0]        target;
    } rob_entry_t;

    function automatic int rob_depth(input int idx_len);
        return 1 << idx_len;
    endfunction
endpackage

// File: rtl/reorder_buffer_entry_array.sv
// ROB entry storage: allocation and retire writes, CDB result capture and two
// operand query ports that forward a same-cycle CDB broadcast.
module rob_entry_array
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_IDX_LEN = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      alloc_en,
    input  logic [ROB_IDX_LEN-1:0]                    alloc_idx,
    input  logic [REG_IDX_LEN-1:0]                    alloc_rd,
    input  logic                                      cdb_valid,
    input  logic [ROB_IDX_LEN-1:0]                    cdb_tag,
    input  logic [XLEN-1:0]                           cdb_data,
    input  logic                                      cdb_mispredict,
    input  logic [XLEN-1:0]                           cdb_target,
    input  logic                                      retire_en,
    input  logic [ROB_IDX_LEN-1:0]                    head_idx,
    output rob_entry_t                                head_entry,
    input  logic [QUERY_PORTS-1:0][ROB_IDX_LEN-1:0]   query_tag,
    output logic [QUERY_PORTS-1:0]                    query_ready,
    output logic [QUERY_PORTS-1:0][XLEN-1:0]          query_data
);
    localparam int DEPTH = rob_depth(ROB_IDX_LEN);

    rob_entry_t entries [DEPTH];
    logic       cdb_accept;

    // Late or duplicate broadcasts (freed or already-completed slot) are dropped.
    assign cdb_accept = cdb_valid && entries[cdb_tag].valid && !entries[cdb_tag].done;
    assign head_entry = entries[head_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            if (cdb_accept) begin
                entries[cdb_tag].done       <= 1'b1;
                entries[cdb_tag].data       <= cdb_data;
                entries[cdb_tag].mispredict <= cdb_mispredict;
                entries[cdb_tag].target     <= cdb_target;
            end
            if (retire_en) entries[head_idx].valid <= 1'b0;
            if (alloc_en)
                entries[alloc_idx] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                        rd: alloc_rd, data: '0, target: '0};
        end
    end

    always_comb begin
        query_ready = '0;
        query_data  = '0;
        for (int p = 0; p < QUERY_PORTS; p++) begin
            if (entries[query_tag[p]].done) begin
                query_ready[p] = 1'b1;
                query_data[p]  = entries[query_tag[p]].data;
            end else if (cdb_valid && cdb_tag == query_tag[p]) begin
                query_ready[p] = 1'b1;
                query_data[p]  = cdb_data;
            end
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: tag allocation, head commit, and flush/redirect
// on a retiring mispredicted control instruction.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_IDX_LEN = 4,
    parameter int ISSUE_WIDTH = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        alloc_valid_i,
    input  logic [REG_IDX_LEN-1:0]                      alloc_rd_i,
    output logic                                        alloc_ready_o,
    output logic [ROB_IDX_LEN-1:0]                      alloc_tag_o,
    input  logic                                        cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0]                      cdb_tag_i,
    input  logic [XLEN-1:0]                             cdb_data_i,
    input  logic                                        cdb_mispredict_i,
    input  logic [XLEN-1:0]                             cdb_target_i,
    input  logic [QUERY_PORTS-1:0][ROB_IDX_LEN-1:0]     query_tag_i,
    output logic [QUERY_PORTS-1:0]                      query_ready_o,
    output logic [QUERY_PORTS-1:0][XLEN-1:0]            query_data_o,
    output logic [ISSUE_WIDTH-1:0]                      speculate_o,
    output logic [ISSUE_WIDTH-1:0][REG_IDX_LEN-1:0]     speculate_idx_o,
    output logic [ISSUE_WIDTH-1:0][ROB_IDX_LEN-1:0]     speculate_data_o,
    output logic [ISSUE_WIDTH-1:0]                      commit_o,
    output logic [ISSUE_WIDTH-1:0][REG_IDX_LEN-1:0]     commit_idx_o,
    output logic [ISSUE_WIDTH-1:0][XLEN-1:0]            commit_data_o,
    output logic                                        fls_o,
    output logic [XLEN-1:0]                             redirect_pc_o,
    output logic                                        empty_o,
    output logic                                        full_o
);
    localparam int DEPTH = rob_depth(ROB_IDX_LEN);
    localparam logic [ROB_IDX_LEN:0] DEPTH_CNT = (ROB_IDX_LEN+1)'(DEPTH);

    if (ISSUE_WIDTH != 1) begin : g_bad_issue_width
        $error("reorder_buffer supports ISSUE_WIDTH == 1 only");
    end

    logic [ROB_IDX_LEN-1:0] head, tail;
    logic [ROB_IDX_LEN:0]   count;
    rob_entry_t             head_entry;
    logic                   commit, flush, alloc_fire;

    assign full_o        = (count == DEPTH_CNT);
    assign empty_o       = (count == '0);
    assign commit        = head_entry.valid && head_entry.done;
    assign flush         = commit && head_entry.mispredict;
    // Readiness ignores a same-cycle commit so the alloc path never waits on retire.
    assign alloc_ready_o = !full_o && !flush;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign alloc_tag_o   = tail;

    assign speculate_o[0]      = alloc_fire;
    assign speculate_idx_o[0]  = alloc_rd_i;
    assign speculate_data_o[0] = tail;
    assign commit_o[0]         = commit;
    assign commit_idx_o[0]     = head_entry.rd;
    assign commit_data_o[0]    = head_entry.data;
    assign fls_o               = flush;
    assign redirect_pc_o       = flush ? head_entry.target : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) tail <= tail + 1'b1;
            if (commit)     head <= head + 1'b1;
            case ({alloc_fire, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    rob_entry_array #(.ROB_IDX_LEN(ROB_IDX_LEN)) u_entries (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .alloc_en       (alloc_fire),
        .alloc_idx      (tail),
        .alloc_rd       (alloc_rd_i),
        .cdb_valid      (cdb_valid_i),
        .cdb_tag        (cdb_tag_i),
        .cdb_data       (cdb_data_i),
        .cdb_mispredict (cdb_mispredict_i),
        .cdb_target     (cdb_target_i),
        .retire_en      (commit),
        .head_idx       (head),
        .head_entry     (head_entry),
        .query_tag      (query_tag_i),
        .query_ready    (query_ready_o),
        .query_data     (query_data_o)
    );
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus randomized checks of reorder_buffer against a program-order queue model.
module tb_reorder_buffer;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alloc_valid_i = 1'b0;
    logic [4:0]       alloc_rd_i = '0;
    logic             alloc_ready_o;
    logic [3:0]       alloc_tag_o;
    logic             cdb_valid_i = 1'b0;
    logic [3:0]       cdb_tag_i = '0;
    logic [31:0]      cdb_data_i = '0;
    logic             cdb_mispredict_i = 1'b0;
    logic [31:0]      cdb_target_i = '0;
    logic [1:0][3:0]  query_tag_i = '0;
    logic [1:0]       query_ready_o;
    logic [1:0][31:0] query_data_o;
    logic [0:0]       speculate_o;
    logic [0:0][4:0]  speculate_idx_o;
    logic [0:0][3:0]  speculate_data_o;
    logic [0:0]       commit_o;
    logic [0:0][4:0]  commit_idx_o;
    logic [0:0][31:0] commit_data_o;
    logic             fls_o;
    logic [31:0]      redirect_pc_o;
    logic             empty_o, full_o;

    reorder_buffer #(.ROB_IDX_LEN(4), .ISSUE_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid_i(alloc_valid_i), .alloc_rd_i(alloc_rd_i),
        .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .cdb_mispredict_i(cdb_mispredict_i), .cdb_target_i(cdb_target_i),
        .query_tag_i(query_tag_i), .query_ready_o(query_ready_o), .query_data_o(query_data_o),
        .speculate_o(speculate_o), .speculate_idx_o(speculate_idx_o),
        .speculate_data_o(speculate_data_o),
        .commit_o(commit_o), .commit_idx_o(commit_idx_o), .commit_data_o(commit_data_o),
        .fls_o(fls_o), .redirect_pc_o(redirect_pc_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: in-flight instructions in program order.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          done;
        bit          misp;
        logic [31:0] data;
        logic [31:0] tgt;
    } ment_t;
    ment_t q[$];
    int    m_tail = 0;
    bit    e_commit, e_fls, e_ready;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic int find_tag(input int t);
        for (int i = 0; i < q.size(); i++) if (q[i].tag == t) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        e_commit = q.size() > 0 && q[0].done;
        e_fls    = e_commit && q[0].misp;
        e_ready  = q.size() < 16 && !e_fls;
        chk("commit_o", commit_o, e_commit);
        if (e_commit) begin
            chk("commit_idx_o", commit_idx_o[0], q[0].rd);
            chk("commit_data_o", commit_data_o[0], q[0].data);
        end
        chk("fls_o", fls_o, e_fls);
        chk("redirect_pc_o", redirect_pc_o, e_fls ? q[0].tgt : 32'h0);
        chk("full_o", full_o, q.size() == 16);
        chk("empty_o", empty_o, q.size() == 0);
        chk("alloc_ready_o", alloc_ready_o, e_ready);
        chk("alloc_tag_o", alloc_tag_o, m_tail);
        chk("speculate_o", speculate_o, alloc_valid_i && e_ready);
        if (alloc_valid_i && e_ready) begin
            chk("speculate_idx_o", speculate_idx_o[0], alloc_rd_i);
            chk("speculate_data_o", speculate_data_o[0], m_tail);
        end
        for (int p = 0; p < 2; p++) begin
            int k;
            k = find_tag(int'(query_tag_i[p]));
            if (k >= 0) begin
                if (q[k].done) begin
                    chk("query_ready_o", query_ready_o[p], 1);
                    chk("query_data_o", query_data_o[p], q[k].data);
                end else if (cdb_valid_i && cdb_tag_i == query_tag_i[p]) begin
                    chk("query_ready_o fwd", query_ready_o[p], 1);
                    chk("query_data_o fwd", query_data_o[p], cdb_data_i);
                end else begin
                    chk("query_ready_o", query_ready_o[p], 0);
                    chk("query_data_o", query_data_o[p], 0);
                end
            end
        end
    endtask

    task automatic model_edge();
        int k;
        if (e_fls) begin
            q.delete();
            m_tail = 0;
            return;
        end
        k = find_tag(int'(cdb_tag_i));
        if (cdb_valid_i && k >= 0 && !q[k].done) begin
            q[k].done = 1;
            q[k].misp = cdb_mispredict_i;
            q[k].data = cdb_data_i;
            q[k].tgt  = cdb_target_i;
        end
        if (e_commit) void'(q.pop_front());
        if (alloc_valid_i && e_ready) begin
            q.push_back('{tag: m_tail, rd: alloc_rd_i, done: 0, misp: 0, data: 0, tgt: 0});
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid_i = 0; alloc_rd_i = 0; cdb_valid_i = 0; cdb_tag_i = 0;
        cdb_data_i = 0; cdb_mispredict_i = 0; cdb_target_i = 0; query_tag_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        q.delete();
        m_tail = 0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic cdb(input int t, input logic [31:0] d, input bit m, input logic [31:0] tg);
        cdb_valid_i = 1; cdb_tag_i = 4'(t); cdb_data_i = d; cdb_mispredict_i = m; cdb_target_i = tg;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst alloc_ready_o", alloc_ready_o, 1);
        chk("rst empty_o", empty_o, 1);
        chk("rst full_o", full_o, 0);
        chk("rst commit_o", commit_o, 0);
        chk("rst fls_o", fls_o, 0);
        chk("rst speculate_o", speculate_o, 0);
        chk("rst alloc_tag_o", alloc_tag_o, 0);
        chk("rst query_ready_o", query_ready_o, 0);

        // Two allocations
        alloc_valid_i = 1; alloc_rd_i = 5;
        #1;
        chk("alloc0 tag", alloc_tag_o, 0);
        chk("alloc0 spec_idx", speculate_idx_o[0], 5);
        chk("alloc0 spec_data", speculate_data_o[0], 0);
        step();
        alloc_rd_i = 6;
        #1;
        chk("alloc1 tag", alloc_tag_o, 1);
        chk("alloc1 spec_idx", speculate_idx_o[0], 6);
        chk("alloc1 spec_data", speculate_data_o[0], 1);
        step();
        idle_inputs();

        // Out-of-order completion, in-order retire
        cdb(1, 32'hBEEF, 0, 0); step();
        #1; chk("no commit while head pending", commit_o, 0);
        cdb(0, 32'h1234, 0, 0); step();
        idle_inputs();
        #1;
        chk("commit0 valid", commit_o, 1);
        chk("commit0 idx", commit_idx_o[0], 5);
        chk("commit0 data", commit_data_o[0], 32'h1234);
        step();
        #1;
        chk("commit1 valid", commit_o, 1);
        chk("commit1 idx", commit_idx_o[0], 6);
        chk("commit1 data", commit_data_o[0], 32'hBEEF);
        step();
        step();

        // Fill to full, commit with alloc held, then wrap to tag 0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc_valid_i = 1; alloc_rd_i = 5'(i + 1);
            step();
        end
        #1;
        chk("fill full_o", full_o, 1);
        chk("fill alloc_ready_o", alloc_ready_o, 0);
        cdb(0, 32'h55, 0, 0); step();
        cdb_valid_i = 0;
        #1;
        chk("full commit_o", commit_o, 1);
        chk("full commit alloc_ready_o", alloc_ready_o, 0);
        step();
        #1;
        chk("wrap alloc_ready_o", alloc_ready_o, 1);
        chk("wrap alloc_tag_o", alloc_tag_o, 0);
        step();
        alloc_valid_i = 0;

        // Same-cycle CDB forwarding to a query port
        query_tag_i[0] = 4'd3;
        cdb(3, 32'hCAFE, 0, 0);
        #1;
        chk("fwd query_ready", query_ready_o[0], 1);
        chk("fwd query_data", query_data_o[0], 32'hCAFE);
        step();
        idle_inputs();

        // Mispredicted head with three younger entries
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid_i = 1; alloc_rd_i = 5'(i + 1); step();
        end
        alloc_valid_i = 0;
        cdb(0, 32'h44, 1, 32'h80000040); step();
        idle_inputs();
        alloc_valid_i = 1; alloc_rd_i = 9;
        #1;
        chk("flush fls_o", fls_o, 1);
        chk("flush redirect", redirect_pc_o, 32'h80000040);
        chk("flush commit_o", commit_o, 1);
        chk("flush alloc_ready_o", alloc_ready_o, 0);
        step();
        alloc_valid_i = 0;
        #1;
        chk("post flush empty_o", empty_o, 1);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            alloc_valid_i = 1; alloc_rd_i = 5'(7 + i); step();
        end
        alloc_valid_i = 0;
        cdb(0, 32'h77, 0, 0); step();
        idle_inputs();
        #1;
        chk("pre-reset commit_o", commit_o, 1);
        #1;
        rst = 0;
        #1;
        chk("async commit_o", commit_o, 0);
        chk("async empty_o", empty_o, 1);
        chk("async full_o", full_o, 0);
        chk("async alloc_ready_o", alloc_ready_o, 1);
        chk("async alloc_tag_o", alloc_tag_o, 0);
        chk("async fls_o", fls_o, 0);
        chk("async speculate_o", speculate_o, 0);
        chk("async query_ready_o", query_ready_o, 0);
        q.delete();
        m_tail = 0;
        @(posedge clk);
        #1;
        rst = 1;

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            int nd[$];
            int t;
            if ($urandom_range(0, 399) == 0) do_reset();
            alloc_valid_i = ($urandom_range(0, 9) < 6);
            alloc_rd_i    = 5'($urandom);
            nd.delete();
            foreach (q[i]) if (!q[i].done) nd.push_back(q[i].tag);
            if (nd.size() > 0 && $urandom_range(0, 4) != 0)
                t = nd[$urandom_range(0, nd.size() - 1)];
            else
                t = int'($urandom_range(0, 15));
            cdb(t, $urandom, ($urandom_range(0, 11) == 0), $urandom);
            cdb_valid_i = ($urandom_range(0, 1) == 1);
            for (int p = 0; p < 2; p++)
                query_tag_i[p] = (q.size() > 0) ? 4'(q[$urandom_range(0, q.size() - 1)].tag)
                                                : 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue for the out-of-order core; directly upstream of register_file.
- Allocates ROB tags at dispatch and drives register_file's speculate_* inputs (tag → rd).
- Captures results from the common data bus (CDB) and retires the head entry in order, driving commit_*.
- On retiring a mispredicted control instruction, raises fls_o (→ register_file fls) and a redirect PC.

Parameters:
- ROB_IDX_LEN, 4, tag width; depth DEPTH = 2**ROB_IDX_LEN.
- ISSUE_WIDTH, 1, lanes. This block supports only 1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_valid_i  in  1  dispatch requests an entry
- alloc_rd_i  in  5  destination register; 0 means none
- alloc_ready_o  out  1  entry available this cycle
- alloc_tag_o  out  ROB_IDX_LEN  tag granted (= tail)
- cdb_valid_i  in  1  result broadcast
- cdb_tag_i  in  ROB_IDX_LEN  producing entry
- cdb_data_i  in  32  result value
- cdb_mispredict_i  in  1  control instruction resolved mispredicted
- cdb_target_i  in  32  correct PC when mispredicted
- query_tag_i  in  2×ROB_IDX_LEN  operand tags from register_file bus
- query_ready_o  out  2  tag's value is available
- query_data_o  out  2×32  value for that tag
- speculate_o  out  ISSUE_WIDTH  → register_file speculate_i
- speculate_idx_o  out  ISSUE_WIDTH×5  → speculate_idx_i
- speculate_data_o  out  ISSUE_WIDTH×ROB_IDX_LEN  → speculate_data_i
- commit_o  out  ISSUE_WIDTH  → commit_i
- commit_idx_o  out  ISSUE_WIDTH×5  → commit_idx_i
- commit_data_o  out  ISSUE_WIDTH×32  → commit_data_i
- fls_o  out  1  flush pulse → register_file fls and the front end
- redirect_pc_o  out  32  fetch target, valid with fls_o
- empty_o, full_o  out  1 each  status

Behaviour:
- State: entry array (valid, done, mispredict, rd, data, target); head and tail pointers (ROB_IDX_LEN bits, natural wrap DEPTH-1 → 0); count (ROB_IDX_LEN+1 bits).
- Reset (rst=0, asynchronous):
  - head, tail and count = 0; all valid/done = 0.
  - Outputs: alloc_ready_o=1, empty_o=1, full_o=0, commit_o=0, fls_o=0, speculate_o=0, alloc_tag_o=0, query_ready_o=0.
  - Reset asserted mid-operation discards all entries immediately.
- Full/empty: full_o = (count == DEPTH); empty_o = (count == 0).
- alloc_ready_o = !full_o && !fls_o. A commit in the same cycle does not free a slot for allocation.
- Allocate (alloc_valid_i && alloc_ready_o):
  - At the edge: entry[tail] ← valid=1, done=0, mispredict=0, rd=alloc_rd_i; then tail++.
  - Combinationally in the same cycle: speculate_o=1, speculate_idx_o=alloc_rd_i, speculate_data_o=tail.
- CDB write: if entry[cdb_tag_i].valid && !done, then at the edge set data, mispredict, target and done=1. A CDB write to an invalid or already-done entry is ignored.
- Commit (combinational from registered state):
  - commit_o = entry[head].valid && entry[head].done.
  - commit_idx_o = rd; commit_data_o = data. rd=0 still retires; register_file ignores x0.
  - At the edge: entry[head].valid ← 0, head++.
- Latency:
  - CDB write to the head in cycle N → commit_o in cycle N+1.
  - An entry allocated in cycle N can first be written by the CDB in cycle N+1.
- Count update: +1 on alloc only, −1 on commit only, unchanged when both occur.
- Flush:
  - fls_o = commit_o && entry[head].mispredict (same cycle); redirect_pc_o = entry[head].target, otherwise 0.
  - The flushing instruction still commits its rd (JAL/JALR link value).
  - Next edge: all valid/done cleared, head = tail = count = 0.
  - Flush overrides that cycle's alloc (alloc_ready_o is already 0) and any CDB write.
- Query, per port p:
  - If entry[query_tag_i[p]].done: ready=1, data from the entry.
  - Else if a CDB write to the same tag is valid this cycle: forward it (ready=1, data=cdb_data_i).
  - Else ready=0, data=0.
- Pointer wrap: tail reaching head with count == DEPTH means full, never empty.

Decomposition:
- oops_structs gains rob_entry_t (valid, done, mispredict, rd[4:0], data[31:0], target[31:0]).
- rv32i_types gains the ROB_DEPTH localparam derived from ROB_IDX_LEN.
- Pointer, count and flush control live in this module. The entry storage with CDB write and two query read ports is the one natural sub-module: rob_entry_array.

Test Plan:
- Reset, then alloc rd=5 and rd=6 → alloc_tag_o 0 then 1; speculate_idx_o 5/6; speculate_data_o 0/1; count=2.
- CDB tag1=0xBEEF, then tag0=0x1234 → no commit until tag0 is done; then commit rd5=0x1234 and rd6=0xBEEF in consecutive cycles.
- Fill all 16 entries → full_o=1, alloc_ready_o=0. Commit one with alloc held high → no alloc that cycle; alloc accepted the next cycle at tag 0 (wrap).
- Query tag3 in the same cycle as CDB tag3=0xCAFE → query_ready_o=1, query_data_o=0xCAFE.
- Head done with mispredict and target=0x80000040; 3 younger entries present → fls_o=1, redirect_pc_o=0x80000040, commit_o=1; next cycle empty_o=1.
- Drive rst low between clock edges while entries are held → outputs return to reset values immediately, without waiting for a clock edge.
